// File: rtl/fb_reg_arbiter_if.sv
// Bus bundle between the two register-bank masters, the arbiter and the bank port.
// The slave modport is the arbiter's view. The master modport is the requester/bank side.
interface fb_reg_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    logic          bk_en;
    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [DW-1:0] bk_wdata;
    logic [DW-1:0] bk_rdata;

    logic [1:0]    gnt;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bk_rdata,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output bk_en, bk_we, bk_addr, bk_wdata,
        output gnt
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bk_rdata,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  bk_en, bk_we, bk_addr, bk_wdata,
        input  gnt
    );
endinterface

// File: rtl/fb_reg_arbiter.sv
// Two-master round-robin arbiter serialising accesses onto the PL config register bank.
// Every transaction takes a fixed IDLE -> ACCESS -> CAPT -> RESP sequence, and all outputs are registered.
module fb_reg_arbiter #(
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fb_reg_arbiter_if.slave     io_bus
);
    localparam int unsigned AW1 = AW + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPT, RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last, w_last_nxt;          // 1 = M1 served last
    logic          r_owner, w_owner_nxt;        // 1 = M1 owns the bank
    logic          r_cmd_we, w_cmd_we_nxt;
    logic [AW-1:0] r_cmd_addr, w_cmd_addr_nxt;
    logic [DW-1:0] r_cmd_wdata, w_cmd_wdata_nxt;
    logic          r_err, w_err_nxt;
    logic [DW-1:0] r_resp, w_resp_nxt;
    logic [1:0]    r_gnt, w_gnt_nxt;
    logic          r_bk_en, w_bk_en_nxt;
    logic          r_bk_we, w_bk_we_nxt;
    logic [AW-1:0] r_bk_addr, w_bk_addr_nxt;
    logic [DW-1:0] r_bk_wdata, w_bk_wdata_nxt;
    logic [1:0]    r_ack, w_ack_nxt;
    logic [1:0]    r_oerr, w_oerr_nxt;
    logic [DW-1:0] r_rdata0, w_rdata0_nxt;
    logic [DW-1:0] r_rdata1, w_rdata1_nxt;

    logic          w_winner;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} < AW1'(4 * NREG));
    endfunction

    // With both masters requesting, the one not served last wins.
    assign w_winner    = (io_bus.m0_req && io_bus.m1_req) ? ~r_last : io_bus.m1_req;
    assign w_sel_we    = w_winner ? io_bus.m1_we    : io_bus.m0_we;
    assign w_sel_addr  = w_winner ? io_bus.m1_addr  : io_bus.m0_addr;
    assign w_sel_wdata = w_winner ? io_bus.m1_wdata : io_bus.m0_wdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_err       <= 1'b0;
            r_resp      <= '0;
            r_gnt       <= 2'b00;
            r_bk_en     <= 1'b0;
            r_bk_we     <= 1'b0;
            r_bk_addr   <= '0;
            r_bk_wdata  <= '0;
            r_ack       <= 2'b00;
            r_oerr      <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_owner     <= w_owner_nxt;
            r_cmd_we    <= w_cmd_we_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_wdata <= w_cmd_wdata_nxt;
            r_err       <= w_err_nxt;
            r_resp      <= w_resp_nxt;
            r_gnt       <= w_gnt_nxt;
            r_bk_en     <= w_bk_en_nxt;
            r_bk_we     <= w_bk_we_nxt;
            r_bk_addr   <= w_bk_addr_nxt;
            r_bk_wdata  <= w_bk_wdata_nxt;
            r_ack       <= w_ack_nxt;
            r_oerr      <= w_oerr_nxt;
            r_rdata0    <= w_rdata0_nxt;
            r_rdata1    <= w_rdata1_nxt;
        end
    end

    // Output registers are loaded with the values belonging to the state being entered.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_owner_nxt     = r_owner;
        w_cmd_we_nxt    = r_cmd_we;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_wdata_nxt = r_cmd_wdata;
        w_err_nxt       = r_err;
        w_resp_nxt      = r_resp;
        w_gnt_nxt       = r_gnt;
        w_bk_en_nxt     = 1'b0;
        w_bk_we_nxt     = 1'b0;
        w_bk_addr_nxt   = '0;
        w_bk_wdata_nxt  = '0;
        w_ack_nxt       = 2'b00;
        w_oerr_nxt      = 2'b00;
        w_rdata0_nxt    = '0;
        w_rdata1_nxt    = '0;

        unique case (r_state)
            IDLE: begin
                w_gnt_nxt = 2'b00;
                if (io_bus.m0_req || io_bus.m1_req) begin
                    w_owner_nxt     = w_winner;
                    w_cmd_we_nxt    = w_sel_we;
                    w_cmd_addr_nxt  = w_sel_addr;
                    w_cmd_wdata_nxt = w_sel_wdata;
                    w_gnt_nxt       = w_winner ? 2'b10 : 2'b01;
                    w_state_nxt     = ACCESS;
                    if (addr_ok(w_sel_addr)) begin
                        w_bk_en_nxt    = 1'b1;
                        w_bk_we_nxt    = w_sel_we;
                        w_bk_addr_nxt  = w_sel_addr;
                        w_bk_wdata_nxt = w_sel_wdata;
                    end
                end
            end
            ACCESS: begin
                w_err_nxt   = !addr_ok(r_cmd_addr);
                w_state_nxt = CAPT;
            end
            CAPT: begin
                w_resp_nxt            = (!r_err && !r_cmd_we) ? io_bus.bk_rdata : '0;
                w_ack_nxt[r_owner]    = 1'b1;
                w_oerr_nxt[r_owner]   = r_err;
                if (r_owner) w_rdata1_nxt = w_resp_nxt;
                else         w_rdata0_nxt = w_resp_nxt;
                w_state_nxt           = RESP;
            end
            RESP: begin
                w_last_nxt  = r_owner;
                w_gnt_nxt   = 2'b00;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io_bus.m0_ack   = r_ack[0];
    assign io_bus.m1_ack   = r_ack[1];
    assign io_bus.m0_err   = r_oerr[0];
    assign io_bus.m1_err   = r_oerr[1];
    assign io_bus.m0_rdata = r_rdata0;
    assign io_bus.m1_rdata = r_rdata1;
    assign io_bus.bk_en    = r_bk_en;
    assign io_bus.bk_we    = r_bk_we;
    assign io_bus.bk_addr  = r_bk_addr;
    assign io_bus.bk_wdata = r_bk_wdata;
    assign io_bus.gnt      = r_gnt;
endmodule

// File: tb/tb_fb_reg_arbiter.sv
// Directed bench for fb_reg_arbiter: reset, single-master accesses, contention,
// address errors and reset mid-transaction, with hand-computed expectations.
module tb_fb_reg_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    fb_reg_arbiter_if #(.AW(5), .DW(32)) bus ();

    fb_reg_arbiter #(.AW(5), .DW(32), .NREG(5)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 5'h04; bus.m0_wdata = 32'hA5A5A5A5;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 5'h08; bus.m1_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.gnt !== 2'b00) $display("FAIL rst_gnt[%0d]: got %b want 00", i, bus.gnt); else n_pass++;
            n_checks++; if (bus.bk_en !== 1'b0) $display("FAIL rst_bk_en[%0d]: got %b want 0", i, bus.bk_en); else n_pass++;
            n_checks++; if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 4'b0)
                $display("FAIL rst_ack_err[%0d]: got %b want 0000", i, {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}); else n_pass++;
            n_checks++; if ({bus.m0_rdata, bus.m1_rdata, bus.bk_wdata} !== 96'h0)
                $display("FAIL rst_data[%0d]: got %h want 0", i, {bus.m0_rdata, bus.m1_rdata, bus.bk_wdata}); else n_pass++;
        end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL rst_first_gnt: got %b want 01", bus.gnt); else n_pass++;
        n_checks++; if (bus.bk_addr !== 5'h04) $display("FAIL rst_first_addr: got %h want 04", bus.bk_addr); else n_pass++;
        drop_reqs();
        tick();
        tick();
        n_checks++; if (bus.m0_ack !== 1'b1 || bus.m1_ack !== 1'b0)
            $display("FAIL rst_first_ack: got m0=%b m1=%b want m0=1 m1=0", bus.m0_ack, bus.m1_ack); else n_pass++;
        tick();
    endtask

    task automatic test_m0_write();
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 5'h08; bus.m0_wdata = 32'h12345678;
        tick();
        n_checks++; if ({bus.bk_en, bus.bk_we} !== 2'b11) $display("FAIL wr_en_we: got %b want 11", {bus.bk_en, bus.bk_we}); else n_pass++;
        n_checks++; if (bus.bk_addr !== 5'h08) $display("FAIL wr_addr: got %h want 08", bus.bk_addr); else n_pass++;
        n_checks++; if (bus.bk_wdata !== 32'h12345678) $display("FAIL wr_wdata: got %h want 12345678", bus.bk_wdata); else n_pass++;
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL wr_gnt: got %b want 01", bus.gnt); else n_pass++;
        drop_reqs();
        tick();
        n_checks++; if ({bus.bk_en, bus.bk_we, bus.bk_addr, bus.bk_wdata} !== 39'h0)
            $display("FAIL wr_bank_idle: got %h want 0", {bus.bk_en, bus.bk_we, bus.bk_addr, bus.bk_wdata}); else n_pass++;
        tick();
        n_checks++; if ({bus.m0_ack, bus.m0_err} !== 2'b10) $display("FAIL wr_ack_err: got %b want 10", {bus.m0_ack, bus.m0_err}); else n_pass++;
        n_checks++; if (bus.m0_rdata !== 32'h0) $display("FAIL wr_rdata: got %h want 0", bus.m0_rdata); else n_pass++;
        tick();
        n_checks++; if ({bus.m0_ack, bus.gnt} !== 3'b000) $display("FAIL wr_done: got %b want 000", {bus.m0_ack, bus.gnt}); else n_pass++;
    endtask

    task automatic test_m1_read();
        bus.bk_rdata = 32'h11111111;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 5'h10; bus.m1_wdata = 32'h0;
        tick();
        n_checks++; if ({bus.bk_en, bus.bk_we, bus.bk_addr} !== {2'b10, 5'h10})
            $display("FAIL rd_bank: got %b_%h want 10_10", {bus.bk_en, bus.bk_we}, bus.bk_addr); else n_pass++;
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL rd_gnt: got %b want 10", bus.gnt); else n_pass++;
        drop_reqs();
        tick();
        bus.bk_rdata = 32'hCAFEF00D;
        tick();
        bus.bk_rdata = 32'hDEADBEEF;
        n_checks++; if ({bus.m1_ack, bus.m1_err} !== 2'b10) $display("FAIL rd_ack_err: got %b want 10", {bus.m1_ack, bus.m1_err}); else n_pass++;
        n_checks++; if (bus.m1_rdata !== 32'hCAFEF00D) $display("FAIL rd_rdata: got %h want cafef00d", bus.m1_rdata); else n_pass++;
        n_checks++; if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== 34'h0)
            $display("FAIL rd_m0_quiet: got %h want 0", {bus.m0_ack, bus.m0_err, bus.m0_rdata}); else n_pass++;
        tick();
        n_checks++; if ({bus.m1_ack, bus.m1_rdata} !== 33'h0) $display("FAIL rd_done: got %h want 0", {bus.m1_ack, bus.m1_rdata}); else n_pass++;
    endtask

    task automatic test_contention();
        logic       exp_en, exp_a0, exp_a1;
        logic [1:0] exp_gnt;
        logic [4:0] exp_addr;
        bus.bk_rdata = 32'h5A5A5A5A;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 5'h0C; bus.m0_wdata = 32'h0BADF00D;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 5'h04; bus.m1_wdata = 32'h0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 16) drop_reqs();
            exp_en   = (c % 4 == 1);
            exp_a0   = (c == 3) || (c == 11);
            exp_a1   = (c == 7) || (c == 15);
            exp_gnt  = (c % 4 == 0) ? 2'b00 : (((c - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = !exp_en ? 5'h00 : (exp_gnt == 2'b01) ? 5'h0C : 5'h04;
            n_checks++; if (bus.bk_en !== exp_en) $display("FAIL cont_bk_en[c%0d]: got %b want %b", c, bus.bk_en, exp_en); else n_pass++;
            n_checks++; if (bus.bk_addr !== exp_addr) $display("FAIL cont_bk_addr[c%0d]: got %h want %h", c, bus.bk_addr, exp_addr); else n_pass++;
            n_checks++; if (bus.gnt !== exp_gnt) $display("FAIL cont_gnt[c%0d]: got %b want %b", c, bus.gnt, exp_gnt); else n_pass++;
            n_checks++; if ({bus.m0_ack, bus.m1_ack} !== {exp_a0, exp_a1})
                $display("FAIL cont_ack[c%0d]: got %b want %b", c, {bus.m0_ack, bus.m1_ack}, {exp_a0, exp_a1}); else n_pass++;
            n_checks++; if (bus.m1_rdata !== (exp_a1 ? 32'h5A5A5A5A : 32'h0))
                $display("FAIL cont_m1_rdata[c%0d]: got %h want %h", c, bus.m1_rdata, exp_a1 ? 32'h5A5A5A5A : 32'h0); else n_pass++;
        end
    endtask

    task automatic test_addr_err();
        logic [4:0] addrs [3];
        logic       wes   [3];
        addrs[0] = 5'h14; wes[0] = 1'b0;
        addrs[1] = 5'h06; wes[1] = 1'b0;
        addrs[2] = 5'h14; wes[2] = 1'b1;
        bus.bk_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            bus.m0_req = 1'b1; bus.m0_we = wes[k]; bus.m0_addr = addrs[k]; bus.m0_wdata = 32'hFFFFFFFF;
            tick();
            n_checks++; if ({bus.bk_en, bus.bk_we, bus.bk_addr, bus.bk_wdata} !== 39'h0)
                $display("FAIL err_bank[%0d]: got %h want 0", k, {bus.bk_en, bus.bk_we, bus.bk_addr, bus.bk_wdata}); else n_pass++;
            n_checks++; if (bus.gnt !== 2'b01) $display("FAIL err_gnt[%0d]: got %b want 01", k, bus.gnt); else n_pass++;
            drop_reqs();
            tick();
            tick();
            n_checks++; if ({bus.m0_ack, bus.m0_err} !== 2'b11) $display("FAIL err_ack_err[%0d]: got %b want 11", k, {bus.m0_ack, bus.m0_err}); else n_pass++;
            n_checks++; if (bus.m0_rdata !== 32'h0) $display("FAIL err_rdata[%0d]: got %h want 0", k, bus.m0_rdata); else n_pass++;
            tick();
            n_checks++; if (bus.m0_err !== 1'b0) $display("FAIL err_clear[%0d]: got %b want 0", k, bus.m0_err); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bus.bk_rdata = 32'h13579BDF;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 5'h00;
        tick();
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL mid_gnt_m1: got %b want 10", bus.gnt); else n_pass++;
        drop_reqs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({bus.m1_ack, bus.gnt, bus.bk_en} !== 4'b0)
            $display("FAIL mid_after_rst: got %b want 0000", {bus.m1_ack, bus.gnt, bus.bk_en}); else n_pass++;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 5'h00;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 5'h00;
        tick();
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL mid_regrant: got %b want 01", bus.gnt); else n_pass++;
        n_checks++; if (bus.m1_ack !== 1'b0) $display("FAIL mid_no_m1_ack: got %b want 0", bus.m1_ack); else n_pass++;
        drop_reqs();
        tick();
        tick();
        n_checks++; if ({bus.m0_ack, bus.m1_ack} !== 2'b10) $display("FAIL mid_m0_ack: got %b want 10", {bus.m0_ack, bus.m1_ack}); else n_pass++;
        n_checks++; if (bus.m0_rdata !== 32'h13579BDF) $display("FAIL mid_m0_rdata: got %h want 13579bdf", bus.m0_rdata); else n_pass++;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.bk_rdata = '0;
        test_reset();
        test_m0_write();
        test_m1_read();
        test_contention();
        test_addr_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fb_reg_arbiter.md
# fb_reg_arbiter

Two-master round-robin arbiter and access sequencer for the PL peripheral configuration register bank (LED_FREQ, BZ_FREQ, LEDR/G/B duty). Master 0 is the FlexBus slave decode path driven by the PS MCU; master 1 is an on-chip PL sequencer, for example a breathing-light engine. The block serialises both masters onto the bank's single access port, one transaction at a time, with a fixed 4-cycle handshake.

## Interface
- AW, 5: byte address width; registers are word-aligned at 0x00..0x10.
- DW, 32: data width.
- NREG, 5: number of bank registers; valid addresses are 0 to 4*NREG-4, step 4.

- CLK  in  1  single clock; all logic is rising-edge.
- RST  in  1  reset; synchronous, active-high.
- M0_REQ / M1_REQ  in  1  request; WE/ADDR/WDATA are valid whenever REQ is high.
- M0_WE / M1_WE  in  1  1 = write, 0 = read.
- M0_ADDR / M1_ADDR  in  AW  byte address.
- M0_WDATA / M1_WDATA  in  DW  write data.
- M0_ACK / M1_ACK  out  1  one-cycle completion pulse.
- M0_ERR / M1_ERR  out  1  address error; valid only with ACK.
- M0_RDATA / M1_RDATA  out  DW  read data; valid only with ACK, 0 otherwise.
- BK_EN  out  1  bank access strobe; exactly one cycle per access.
- BK_WE  out  1  bank write enable; qualified by BK_EN.
- BK_ADDR  out  AW  bank byte address.
- BK_WDATA  out  DW  bank write data.
- BK_RDATA  in  DW  bank read data; valid the cycle after BK_EN.
- GNT  out  2  one-hot current owner (bit0 = M0); 0 in IDLE.

## Operation
- FSM states: IDLE, ACCESS, CAPT, RESP.
- **IDLE**
  - If no REQ is high, stay in IDLE.
  - Otherwise select a winner. With one requester, that master wins. With both, the master not served last wins.
  - Latch the winner's WE, ADDR and WDATA into an internal command register. Set the owner. Go to ACCESS.
- **ACCESS**
  - If the latched address is valid (ADDR[1:0]==0 and ADDR < 4*NREG): BK_EN=1; BK_WE, BK_ADDR and BK_WDATA come from the command register.
  - If the address is invalid: BK_EN=0 and an internal error flag is set.
  - Go to CAPT.
- **CAPT**
  - For a valid read, capture BK_RDATA into the response register.
  - For a write or an invalid address, load 0 into the response register.
  - Go to RESP.
- **RESP**
  - The owner's ACK=1, its RDATA = response register, its ERR = error flag.
  - Record the owner as last-served. Go to IDLE.
- Handshake rules:
  - REQ is sampled only in IDLE.
  - A master that keeps REQ high in the cycle after its ACK issues a new transaction.
  - Dropping REQ before ACK does not abort: the latched command completes and ACK still pulses.
- Invalid-address accesses never touch the bank: writes are dropped and reads return 0 with ERR=1.
- BK_WE, BK_ADDR and BK_WDATA are 0 whenever BK_EN=0.
- The non-owner's ACK, ERR and RDATA stay 0 at all times.
- Round-robin state: last-served resets to M1, so M0 wins the first simultaneous request.
- Starvation bound: under continuous contention each master gets every other slot.
- All outputs are registered or decoded from registered state only; there is no combinational path from REQ to any output.

## Timing
- Reset values: all outputs 0; state IDLE; last-served = M1; command, response and error registers all 0.
- RST high at any edge, mid-transaction: return to IDLE next cycle. No ACK is issued for the in-flight access. BK_EN is 0 from the next cycle.
- Latency, with REQ first seen high in IDLE during cycle 0:
  - Cycle 1: BK_EN, GNT set.
  - Cycle 2: BK_RDATA sampled.
  - Cycle 3: ACK, RDATA, ERR.
  - Cycle 4: IDLE, REQ resampled.
- Throughput: one transaction per 4 cycles, regardless of which master wins.
- Simultaneous REQ rising on both masters in the same cycle: resolved by last-served; the loser waits exactly 4 cycles.
- A REQ arriving while the FSM is busy is held by its master and served at the next IDLE.

## Test plan
- **Reset:** hold RST high 3 cycles with REQs high -> all outputs 0 and GNT=0; after release, M0 is served first.
- **M0 write:** M0 write addr 0x08, data 0x12345678 ->
  - cycle 1: BK_EN=1, BK_WE=1, BK_ADDR=0x08, BK_WDATA=0x12345678, GNT=01;
  - cycle 3: M0_ACK=1, M0_ERR=0, M0_RDATA=0.
- **M1 read:** M1 read addr 0x10, bank returns 0xCAFEF00D in cycle 2 -> M1_RDATA=0xCAFEF00D with M1_ACK in cycle 3; M0 outputs stay 0.
- **Contention:** both REQs held high for 16 cycles -> ACKs arrive M0, M1, M0, M1, 4 cycles apart; BK_EN pulses at cycles 1, 5, 9, 13.
- **Address errors:** M0 reads 0x14, then 0x06 -> BK_EN stays 0; M0_ACK=1, M0_ERR=1, M0_RDATA=0 for both. A write to 0x14 leaves bank outputs at 0.
- **Reset mid-transaction:** RST pulsed in CAPT of an M1 read -> no M1_ACK, GNT=0 next cycle; a following simultaneous request is granted to M0.
